dcache_mem_arbiter: RTL

//  Shares the single 256-bit data-memory port between two line-fill requesters:

---
 rtl/dcache_mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: round-robin arbiter sharing one 256-bit data-memory
// port between the instruction cache (port 0) and the data cache (port 1).
// One transaction at a time, grant held until mem_ack_i, memory-side
// outputs registered, sticky watchdog flag for a memory that never answers.
module dcache_mem_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  // port 0: instruction cache
  input  logic         m0_enable_i,
  input  logic         m0_write_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [255:0] m0_data_i,
  output logic [255:0] m0_data_o,
  output logic         m0_ack_o,
  // port 1: data cache controller
  input  logic         m1_enable_i,
  input  logic         m1_write_i,
  input  logic [31:0]  m1_addr_i,
  input  logic [255:0] m1_data_i,
  output logic [255:0] m1_data_o,
  output logic         m1_ack_o,
  // memory side
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  // status
  output logic [1:0]   grant_o,
  output logic         timeout_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

  state_t         state_q;
  logic [1:0]     grant_q;
  logic           last_q;      // index of the port served most recently
  logic [CNT_W-1:0] wd_q;
  logic           timeout_q;
  logic           mem_enable_q;
  logic           mem_write_q;
  logic [31:0]    mem_addr_q;
  logic [255:0]   mem_data_q;

  logic           any_req;
  logic           win_d;       // index of the port that wins arbitration now

  // Pick the winner: a sole requester wins; on a tie the port not served last.
  always_comb begin
    any_req = m0_enable_i | m1_enable_i;
    if (m0_enable_i && m1_enable_i) begin
      win_d = ~last_q;
    end else begin
      win_d = m1_enable_i;
    end
  end

  // Arbitration FSM with registered memory-side outputs and watchdog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_q       <= 1'b1;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            mem_enable_q <= 1'b1;
            mem_write_q  <= win_d ? m1_write_i : m0_write_i;
            mem_addr_q   <= win_d ? m1_addr_i  : m0_addr_i;
            mem_data_q   <= win_d ? m1_data_i  : m0_data_i;
            grant_q      <= win_d ? 2'b10 : 2'b01;
            wd_q         <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            // Dropping to IDLE guarantees a low cycle on mem_enable_o, so a
            // requester holding enable is re-arbitrated as a new transaction.
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            grant_q      <= 2'b00;
            last_q       <= grant_q[1];
            state_q      <= IDLE;
          end else begin
            // The transaction keeps waiting; the flag only reports the stall.
            if (wd_q == WD_LAST) begin
              timeout_q <= 1'b1;
            end
            if (wd_q != '1) begin
              wd_q <= wd_q + WD_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;

  // Acks go only to the owner; grant is 00 in IDLE so stray acks are dropped.
  assign m0_ack_o  = mem_ack_i & grant_q[0];
  assign m1_ack_o  = mem_ack_i & grant_q[1];
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

endmodule
